cr_huf_comp_is_arb: RTL



---
 rtl/cr_huf_comp_is_arb_if.sv | 65 ++++++
 rtl/cr_huf_comp_is_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cr_huf_comp_is_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cr_huf_comp_is_arb_if                                  |
// | Description : Requester, sort-engine and status signals of the arb.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface cr_huf_comp_is_arb_if #(
  parameter int DAT_WIDTH   = 10,
  parameter int CNT_WIDTH   = 16,
  parameter int SEQID_WIDTH = 8
);
  logic                   req0_vld;
  logic [DAT_WIDTH-1:0]   req0_sym;
  logic [CNT_WIDTH-1:0]   req0_cnt;
  logic [SEQID_WIDTH-1:0] req0_seq_id;
  logic                   req0_eob;
  logic                   req0_rd;
  logic                   req1_vld;
  logic [DAT_WIDTH-1:0]   req1_sym;
  logic [CNT_WIDTH-1:0]   req1_cnt;
  logic [SEQID_WIDTH-1:0] req1_seq_id;
  logic                   req1_eob;
  logic                   req1_rd;
  logic                   is_vld;
  logic [DAT_WIDTH-1:0]   is_sym;
  logic [CNT_WIDTH-1:0]   is_cnt;
  logic [SEQID_WIDTH-1:0] is_seq_id;
  logic                   is_eob;
  logic                   is_src;
  logic                   is_rd;
  logic                   arb_busy;
  logic                   arb_seq_err;
`ifdef CR_HUF_COMP_IS_ARB_STATS_EN
  logic [15:0]            blk_cnt0;
  logic [15:0]            blk_cnt1;
  logic [15:0]            max_blk_len;

  modport master (
    input  req0_vld, req0_sym, req0_cnt, req0_seq_id, req0_eob,
    input  req1_vld, req1_sym, req1_cnt, req1_seq_id, req1_eob, is_rd,
    output req0_rd, req1_rd, is_vld, is_sym, is_cnt, is_seq_id, is_eob, is_src,
    output arb_busy, arb_seq_err, blk_cnt0, blk_cnt1, max_blk_len
  );
  modport slave (
    output req0_vld, req0_sym, req0_cnt, req0_seq_id, req0_eob,
    output req1_vld, req1_sym, req1_cnt, req1_seq_id, req1_eob, is_rd,
    input  req0_rd, req1_rd, is_vld, is_sym, is_cnt, is_seq_id, is_eob, is_src,
    input  arb_busy, arb_seq_err, blk_cnt0, blk_cnt1, max_blk_len
  );
`else
  modport master (
    input  req0_vld, req0_sym, req0_cnt, req0_seq_id, req0_eob,
    input  req1_vld, req1_sym, req1_cnt, req1_seq_id, req1_eob, is_rd,
    output req0_rd, req1_rd, is_vld, is_sym, is_cnt, is_seq_id, is_eob, is_src,
    output arb_busy, arb_seq_err
  );
  modport slave (
    output req0_vld, req0_sym, req0_cnt, req0_seq_id, req0_eob,
    output req1_vld, req1_sym, req1_cnt, req1_seq_id, req1_eob, is_rd,
    input  req0_rd, req1_rd, is_vld, is_sym, is_cnt, is_seq_id, is_eob, is_src,
    input  arb_busy, arb_seq_err
  );
`endif
endinterface
`default_nettype wire

// File: rtl/cr_huf_comp_is_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cr_huf_comp_is_arb                                     |
// | Description : Block-granular round-robin arbiter sharing one sort    |
// |               engine between two requesters; one-entry output stage. |
// |               Optional block statistics: CR_HUF_COMP_IS_ARB_STATS_EN |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cr_huf_comp_is_arb #(
  parameter int DAT_WIDTH   = 10,
  parameter int CNT_WIDTH   = 16,
  parameter int SEQID_WIDTH = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  cr_huf_comp_is_arb_if.master   bus
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_owner_q, last_owner_d;
  logic                   eob_taken_q, eob_taken_d;
  logic                   first_q, first_d;
  logic [SEQID_WIDTH-1:0] blk_seq_q, blk_seq_d;
  logic                   seq_err_q, seq_err_d;
  logic                   is_vld_q, is_vld_d;
  logic                   is_eob_q, is_eob_d;
  logic                   is_src_q, is_src_d;
  logic [DAT_WIDTH-1:0]   is_sym_q, is_sym_d;
  logic [CNT_WIDTH-1:0]   is_cnt_q, is_cnt_d;
  logic [SEQID_WIDTH-1:0] is_seq_q, is_seq_d;

  logic                   w_own_vld;
  logic                   w_eob;
  logic [DAT_WIDTH-1:0]   w_sym;
  logic [CNT_WIDTH-1:0]   w_cnt;
  logic [SEQID_WIDTH-1:0] w_seq;
  logic                   w_pop;

  assign w_own_vld = owner_q ? bus.req1_vld    : bus.req0_vld;
  assign w_eob     = owner_q ? bus.req1_eob    : bus.req0_eob;
  assign w_sym     = owner_q ? bus.req1_sym    : bus.req0_sym;
  assign w_cnt     = owner_q ? bus.req1_cnt    : bus.req0_cnt;
  assign w_seq     = owner_q ? bus.req1_seq_id : bus.req0_seq_id;
  assign w_pop     = (state_q == ST_BUSY) && w_own_vld &&
                     (!is_vld_q || bus.is_rd) && !eob_taken_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    eob_taken_d  = eob_taken_q;
    first_d      = first_q;
    blk_seq_d    = blk_seq_q;
    seq_err_d    = 1'b0;
    is_vld_d     = is_vld_q;
    is_eob_d     = is_eob_q;
    is_src_d     = is_src_q;
    is_sym_d     = is_sym_q;
    is_cnt_d     = is_cnt_q;
    is_seq_d     = is_seq_q;

    case (state_q)
      ST_IDLE: begin
        eob_taken_d = 1'b0;
        if (bus.req0_vld || bus.req1_vld) begin
          state_d = ST_BUSY;
          first_d = 1'b1;
          owner_d = (bus.req0_vld && bus.req1_vld) ? !last_owner_q : bus.req1_vld;
        end
      end
      default: begin
        if (w_pop && w_eob) begin
          state_d      = ST_IDLE;
          eob_taken_d  = 1'b1;
          last_owner_d = owner_q;
        end
      end
    endcase

    // A fresh load takes priority over the engine's pop of the old entry.
    if (w_pop) begin
      is_vld_d = 1'b1;
      is_eob_d = w_eob;
      is_src_d = owner_q;
      is_sym_d = w_sym;
      is_cnt_d = w_cnt;
      is_seq_d = w_seq;
      if (first_q) begin
        first_d   = 1'b0;
        blk_seq_d = w_seq;
      end else if (w_seq != blk_seq_q) begin
        seq_err_d = 1'b1;
      end
    end else if (bus.is_rd) begin
      is_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      eob_taken_q  <= 1'b0;
      first_q      <= 1'b0;
      blk_seq_q    <= '0;
      seq_err_q    <= 1'b0;
      is_vld_q     <= 1'b0;
      is_eob_q     <= 1'b0;
      is_src_q     <= 1'b0;
      is_sym_q     <= '0;
      is_cnt_q     <= '0;
      is_seq_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      eob_taken_q  <= eob_taken_d;
      first_q      <= first_d;
      blk_seq_q    <= blk_seq_d;
      seq_err_q    <= seq_err_d;
      is_vld_q     <= is_vld_d;
      is_eob_q     <= is_eob_d;
      is_src_q     <= is_src_d;
      is_sym_q     <= is_sym_d;
      is_cnt_q     <= is_cnt_d;
      is_seq_q     <= is_seq_d;
    end
  end

  assign bus.req0_rd     = w_pop && !owner_q;
  assign bus.req1_rd     = w_pop && owner_q;
  assign bus.is_vld      = is_vld_q;
  assign bus.is_eob      = is_eob_q;
  assign bus.is_src      = is_src_q;
  assign bus.is_sym      = is_sym_q;
  assign bus.is_cnt      = is_cnt_q;
  assign bus.is_seq_id   = is_seq_q;
  assign bus.arb_busy    = (state_q == ST_BUSY);
  assign bus.arb_seq_err = seq_err_q;

`ifdef CR_HUF_COMP_IS_ARB_STATS_EN
  logic [15:0] blk_cnt0_q, blk_cnt0_d;
  logic [15:0] blk_cnt1_q, blk_cnt1_d;
  logic [15:0] max_len_q, max_len_d;
  logic [15:0] len_q, len_d;
  logic [15:0] w_len_inc;

  assign w_len_inc = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;

  always_comb begin
    blk_cnt0_d = blk_cnt0_q;
    blk_cnt1_d = blk_cnt1_q;
    max_len_d  = max_len_q;
    len_d      = (state_q == ST_IDLE) ? 16'd0 : len_q;
    if (w_pop) begin
      len_d = w_len_inc;
      if (w_eob) begin
        if (owner_q) blk_cnt1_d = blk_cnt1_q + 16'd1;
        else         blk_cnt0_d = blk_cnt0_q + 16'd1;
        if (w_len_inc > max_len_q) max_len_d = w_len_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt0_q <= '0;
      blk_cnt1_q <= '0;
      max_len_q  <= '0;
      len_q      <= '0;
    end else begin
      blk_cnt0_q <= blk_cnt0_d;
      blk_cnt1_q <= blk_cnt1_d;
      max_len_q  <= max_len_d;
      len_q      <= len_d;
    end
  end

  assign bus.blk_cnt0    = blk_cnt0_q;
  assign bus.blk_cnt1    = blk_cnt1_q;
  assign bus.max_blk_len = max_len_q;
`endif

endmodule
`default_nettype wire
